// File: rtl/seq_div_16by8.sv
// seq_div_16by8 - multi-cycle restoring divider.
// Divides a 2*DW-bit dividend by a DW-bit divisor and resolves one quotient
// bit per clock. Valid/ready handshakes sit on both the operand and the
// result side. The result is held stable until the consumer accepts it.
// Optional feature macro: SEQ_DIV_ZERO_BYPASS_EN. When it is defined, a zero
// divisor skips the iterations and the block presents its result one clock
// after accept. When it is undefined, a zero divisor runs the full 2*DW
// iterations and produces the same data values.
module seq_div_16by8 #(
    parameter int DW = 8,
    parameter int CW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   quotient,
    output logic [DW-1:0]     remainder,
    output logic              div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(2*DW-1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              armed;
    logic              accept;
    logic              zero_div_in;

    logic [DW:0]       part_rem;
    logic [2*DW-1:0]   shift_reg;
    logic [DW-1:0]     dvsr;
    logic [CW-1:0]     count;
    logic              dbz;

    logic [DW+1:0]     shifted;
    logic              fits;
    logic [DW:0]       rem_next;

    // The block only advertises readiness once it has seen a clock edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    assign in_ready    = armed && (state == IDLE);
    assign accept      = in_valid && in_ready;
    assign zero_div_in = (divisor == '0);

    // One restoring step. The bit shifted out of the top of the partial
    // remainder stays in the compare, so an oversized value is never taken as small.
    always_comb begin
        shifted  = {part_rem, shift_reg[2*DW-1]};
        fits     = (shifted >= {2'b00, dvsr});
        rem_next = shifted[DW:0];
        if (fits) begin
            rem_next = shifted[DW:0] - {1'b0, dvsr};
        end
    end

    // Next-state logic for the IDLE -> BUSY -> DONE -> IDLE sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SEQ_DIV_ZERO_BYPASS_EN
                    if (zero_div_in) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                    end
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                if (count == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: capture operands on accept, iterate while busy, hold while done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_rem  <= '0;
            shift_reg <= '0;
            dvsr      <= '0;
            count     <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef SEQ_DIV_ZERO_BYPASS_EN
                        if (zero_div_in) begin
                            part_rem  <= {1'b0, dividend[DW-1:0]};
                            shift_reg <= '1;
                            dvsr      <= divisor;
                            count     <= '0;
                            dbz       <= 1'b1;
                        end else begin
                            part_rem  <= '0;
                            shift_reg <= dividend;
                            dvsr      <= divisor;
                            count     <= '0;
                            dbz       <= 1'b0;
                        end
`else
                        part_rem  <= '0;
                        shift_reg <= dividend;
                        dvsr      <= divisor;
                        count     <= '0;
                        dbz       <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    part_rem  <= rem_next;
                    shift_reg <= {shift_reg[2*DW-2:0], fits};
                    count     <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        dbz <= (dvsr == '0);
                    end
                end
                default: begin
                    part_rem  <= part_rem;
                    shift_reg <= shift_reg;
                end
            endcase
        end
    end

    assign out_valid   = (state == DONE);
    assign quotient    = shift_reg;
    assign remainder   = part_rem[DW-1:0];
    assign div_by_zero = dbz;

endmodule

// File: doc/seq_div_16by8.md
Name: seq_div_16by8

Overview:
- Multi-cycle restoring divider: the inverse of the 8x8 Karatsuba multiplier.
- Takes a 2*DW-bit dividend (a product-width value) and a DW-bit divisor.
- Returns a 2*DW-bit quotient and a DW-bit remainder.
- Sits downstream of the multiplier path; used for reduction checks and modulus reduction of products in the Montgomery datapath.
- Valid/ready on both sides; one quotient bit resolved per clock.

Parameters:
- DW, 8, divisor and remainder width; dividend and quotient are 2*DW bits.
- CW, 5, iteration counter width; must satisfy 2^CW >= 2*DW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dividend/divisor presented.
- in_ready  output  1  block can accept an operand pair.
- dividend  input  2*DW  numerator.
- divisor  input  DW  denominator.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts result.
- quotient  output  2*DW  floor(dividend/divisor).
- remainder  output  DW  dividend mod divisor.
- div_by_zero  output  1  result is from a zero divisor.

Behaviour:
- Reset: one clock, rst_n asynchronous active-low; asserting rst_n low immediately forces:
  - state=IDLE, in_ready=0 while in reset;
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0;
  - internal partial remainder and counter = 0.
  - After release, in_ready=1 from the first clk edge onward.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch dividend into the quotient/shift register, latch divisor, clear the (DW+1)-bit partial remainder, counter=0, go to BUSY.
- State BUSY:
  - in_ready=0.
  - Each cycle: shift {partial remainder, shift register} left by 1.
  - If shifted partial remainder >= {1'b0,divisor}: subtract the divisor, set the shift-register LSB=1; else LSB=0.
  - Counter increments; after iteration 2*DW-1, go to DONE.
- State DONE:
  - out_valid=1; quotient, remainder and div_by_zero are held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE; out_valid falls on the same edge.
- Latency: out_valid is first high exactly 2*DW clocks after the accept edge (16 for DW=8).
  - Throughput: one operation per 2*DW+2 cycles minimum.
  - No new accept occurs while BUSY or DONE.
- Arithmetic:
  - Unsigned only; the partial remainder is DW+1 bits so compare/subtract never overflows.
  - quotient*divisor+remainder == dividend for every divisor != 0, and remainder < divisor.
- Divide by zero (divisor==0): quotient=all ones, remainder=dividend[DW-1:0], div_by_zero=1. Natural restoring behaviour yields exactly these data values.
- Dividend < divisor: quotient=0, remainder=dividend.
- Dividend==0: quotient=0, remainder=0, full latency.
- in_valid while not in IDLE: ignored; the operands are not captured.
- Input operands need only be stable on the accept edge.
- Reset asserted during BUSY or DONE: the operation is abandoned, all outputs go to reset values, and no result is emitted after release.

Optional Feature:
- Macro: SEQ_DIV_ZERO_BYPASS_EN.
- Defined:
  - A zero divisor is detected on the accept edge; the block goes directly from IDLE to DONE.
  - out_valid is high 1 clock after accept, with quotient=all ones, remainder=dividend[DW-1:0], div_by_zero=1.
- Undefined:
  - A zero divisor runs the full 2*DW iterations.
  - div_by_zero is set from the latched divisor==0; data values are identical.
  - Latency is always 2*DW.

Test Plan:
- Basic divide: dividend=1000, divisor=7 -> after 16 clocks out_valid=1, quotient=142, remainder=6, div_by_zero=0.
- Maximum operands: dividend=0xFFFF, divisor=0xFF -> quotient=0x0101, remainder=0.
- Small-over-large: dividend=100, divisor=200 -> quotient=0, remainder=100.
- Divide by zero: dividend=0x3039, divisor=0 -> quotient=0xFFFF, remainder=0x39, div_by_zero=1.
  - Latency is 16 clocks without SEQ_DIV_ZERO_BYPASS_EN, 1 clock with it.
- Backpressure:
  - dividend=0x1234, divisor=0x10 with out_ready held low 5 cycles after out_valid -> quotient=0x0123, remainder=4, stable all 5 cycles.
  - in_ready=0 throughout, a second in_valid pulse is ignored, and in_ready=1 the cycle after the handshake.
- Reset mid-operation: start 1000/7, drop rst_n at iteration 8 -> out_valid=0 and quotient=0 immediately.
  - After release, no stray out_valid.
  - A fresh 255/1 returns quotient=255, remainder=0.
